// File: rtl/bu_rsp_queue_pkg.sv
// -----------------------------------------------------------------------------
// bu_rsp_queue_pkg
// Shared definitions for the buffer-unit response path.
//   - NOU_* field widths, mirroring nou_define.h, so that every file in this
//     slice agrees on them even when compiled standalone
//   - nou_rsp_entry_t: packed response entry, reused by the response consumer
//   - helper for the buffer-release decision
// -----------------------------------------------------------------------------
`ifndef NOU_DEFINE_H
`define NOU_DEFINE_H
`define NOU_SID_WIDTH          4
`define NOU_RSP_TYPE_ID_WIDTH  3
`define NOU_BUF_ID_WIDTH       4
`define NOU_ERR_CODE_WIDTH     4
`define NOU_BUF_RM_WIDTH       4
`endif

package bu_rsp_queue_pkg;

    localparam int SID_W      = `NOU_SID_WIDTH;
    localparam int RTYPE_W    = `NOU_RSP_TYPE_ID_WIDTH;
    localparam int BUF_ID_W   = `NOU_BUF_ID_WIDTH;
    localparam int ERR_CODE_W = `NOU_ERR_CODE_WIDTH;
    localparam int RM_W       = `NOU_BUF_RM_WIDTH;

    // One retired response as it sits in the queue.
    typedef struct packed {
        logic [SID_W-1:0]      sid;
        logic [RTYPE_W-1:0]    rtype;
        logic [BUF_ID_W-1:0]   buf_id;
        logic                  status;   // 1 = error
        logic [ERR_CODE_W-1:0] err_code;
        logic [RM_W-1:0]       rm;       // buffer release mask
    } nou_rsp_entry_t;

    // An entry frees buffer space only when its release mask is non-zero.
    function automatic logic needs_release(input nou_rsp_entry_t e);
        return |e.rm;
    endfunction

endpackage

// File: rtl/bu_rsp_queue_if.sv
// -----------------------------------------------------------------------------
// bu_rsp_queue_if
// Bundles the three handshake groups of the response queue:
//   in_*      : retire entry from the upstream retire register + retire_keep
//   rsp_*     : head-of-queue response with valid/ready
//   buf_rel_* : registered buffer release pulse
// modport slave  : the queue's view
// modport master : the surrounding logic's (or a bench's) view
// -----------------------------------------------------------------------------
interface bu_rsp_queue_if;
    import bu_rsp_queue_pkg::*;

    // retire side
    logic                  in_vld;
    logic [SID_W-1:0]      in_sid;
    logic [RTYPE_W-1:0]    in_rtype;
    logic [BUF_ID_W-1:0]   in_buf_id;
    logic                  in_status;
    logic [ERR_CODE_W-1:0] in_err_code;
    logic [RM_W-1:0]       in_rm;
    logic                  retire_keep;

    // response side
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [SID_W-1:0]      rsp_sid;
    logic [RTYPE_W-1:0]    rsp_rtype;
    logic [BUF_ID_W-1:0]   rsp_buf_id;
    logic                  rsp_status;
    logic [ERR_CODE_W-1:0] rsp_err_code;

    // buffer release
    logic                  buf_rel_vld;
    logic [BUF_ID_W-1:0]   buf_rel_id;
    logic [RM_W-1:0]       buf_rel_rm;

    modport slave (
        input  in_vld, in_sid, in_rtype, in_buf_id, in_status, in_err_code, in_rm,
        output retire_keep,
        output rsp_vld, rsp_sid, rsp_rtype, rsp_buf_id, rsp_status, rsp_err_code,
        input  rsp_rdy,
        output buf_rel_vld, buf_rel_id, buf_rel_rm
    );

    modport master (
        output in_vld, in_sid, in_rtype, in_buf_id, in_status, in_err_code, in_rm,
        input  retire_keep,
        input  rsp_vld, rsp_sid, rsp_rtype, rsp_buf_id, rsp_status, rsp_err_code,
        output rsp_rdy,
        input  buf_rel_vld, buf_rel_id, buf_rel_rm
    );

endinterface

// File: rtl/bu_rsp_fifo.sv
// -----------------------------------------------------------------------------
// bu_rsp_fifo
// DEPTH-entry FIFO of nou_rsp_entry_t. No write-to-read bypass: a pushed entry
// shows on o_rdata no earlier than the following cycle. Storage is not reset;
// o_rdata is meaningful only while o_empty = 0.
// Ports:
//   clk, rstn         clock, async active-low reset (pointers/occupancy)
//   i_push, i_wdata   write request and data (ignored when full)
//   i_pop             read request (ignored when empty)
//   o_rdata           oldest entry
//   o_occ             occupancy, 0..DEPTH
//   o_full, o_empty   decoded from the registered occupancy
// -----------------------------------------------------------------------------
module bu_rsp_fifo
    import bu_rsp_queue_pkg::*;
#(
    parameter int DEPTH = 4,               // power of two, >= 2
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           i_push,
    input  nou_rsp_entry_t i_wdata,
    input  logic           i_pop,
    output nou_rsp_entry_t o_rdata,
    output logic [AW:0]    o_occ,
    output logic           o_full,
    output logic           o_empty
);

    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    nou_rsp_entry_t r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_occ;

    logic w_wr;
    logic w_rd;

    assign o_full  = (r_occ == FULL_OCC);
    assign o_empty = (r_occ == '0);
    assign o_occ   = r_occ;
    assign o_rdata = r_mem[r_rptr];

    // Guard locally so a misbehaving caller cannot corrupt the pointers.
    assign w_wr = i_push & ~o_full;
    assign w_rd = i_pop  & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH for free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/bu_rsp_queue.sv
// -----------------------------------------------------------------------------
// bu_rsp_queue
// Response queue between the retire register stage and the response consumer.
// Retired entries are queued in FIFO order and presented on rsp_*; popping an
// entry with a non-zero release mask emits a one-cycle buffer release pulse,
// and popping an error entry bumps a saturating error counter.
// Ports:
//   clk, rstn   clock, async active-low reset
//   bus         bu_rsp_queue_if.slave: in_* / retire_keep, rsp_*, buf_rel_*
//   err_clr     synchronous clear of err_cnt (wins over an increment)
//   err_cnt     number of error responses delivered, saturating
//   occ         current queue occupancy
// -----------------------------------------------------------------------------
module bu_rsp_queue
    import bu_rsp_queue_pkg::*;
#(
    parameter int DEPTH     = 4,           // power of two, >= 2
    parameter int ERR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    bu_rsp_queue_if.slave          bus,
    input  logic                   err_clr,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [$clog2(DEPTH):0] occ
);

    nou_rsp_entry_t          w_in_entry;
    nou_rsp_entry_t          w_head;
    logic [$clog2(DEPTH):0]  w_occ;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;

    logic                    r_rel_vld;
    logic [BUF_ID_W-1:0]     r_rel_id;
    logic [RM_W-1:0]         r_rel_rm;
    logic [ERR_CNT_W-1:0]    r_err_cnt;

    assign w_in_entry = '{
        sid:      bus.in_sid,
        rtype:    bus.in_rtype,
        buf_id:   bus.in_buf_id,
        status:   bus.in_status,
        err_code: bus.in_err_code,
        rm:       bus.in_rm
    };

    // Push depends only on registered fullness: a pop in the same cycle does
    // not make room, which keeps rsp_rdy out of the retire_keep/push path.
    assign w_push = bus.in_vld & ~w_full;
    assign w_pop  = ~w_empty & bus.rsp_rdy;

    bu_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_wdata (w_in_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_occ   (w_occ),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.retire_keep  = w_full;
    assign bus.rsp_vld      = ~w_empty;
    assign bus.rsp_sid      = w_head.sid;
    assign bus.rsp_rtype    = w_head.rtype;
    assign bus.rsp_buf_id   = w_head.buf_id;
    assign bus.rsp_status   = w_head.status;
    assign bus.rsp_err_code = w_head.err_code;

    // Release pulse: registered, one cycle per qualifying pop. id/rm hold the
    // last released values between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rel_vld <= 1'b0;
            r_rel_id  <= '0;
            r_rel_rm  <= '0;
        end else begin
            r_rel_vld <= w_pop & needs_release(w_head);
            if (w_pop & needs_release(w_head)) begin
                r_rel_id <= w_head.buf_id;
                r_rel_rm <= w_head.rm;
            end
        end
    end

    assign bus.buf_rel_vld = r_rel_vld;
    assign bus.buf_rel_id  = r_rel_id;
    assign bus.buf_rel_rm  = r_rel_rm;

    // Error counter: clear has priority, increment saturates at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_pop && w_head.status && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
    assign occ     = w_occ;

endmodule

// File: tb/tb_bu_rsp_queue.sv
module tb_bu_rsp_queue;
    import bu_rsp_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int ERR_W = 3;                 // small so saturation is reachable
    localparam int OW    = $clog2(DEPTH) + 1;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             err_clr = 1'b0;
    logic [ERR_W-1:0] err_cnt;
    logic [OW-1:0]    occ;

    bu_rsp_queue_if bus();

    bu_rsp_queue #(.DEPTH(DEPTH), .ERR_CNT_W(ERR_W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .err_clr (err_clr),
        .err_cnt (err_cnt),
        .occ     (occ)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference: a plain queue plus a few scalars.
    nou_rsp_entry_t      mq[$];
    int                  m_err = 0;
    logic                m_rel_vld = 1'b0;
    logic [BUF_ID_W-1:0] m_rel_id = '0;
    logic [RM_W-1:0]     m_rel_rm = '0;

    typedef struct {
        int vld; int sid; int bid; int rm; int rdy;
        int x_occ; int x_vld; int x_sid; int x_keep; int x_rel;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input nou_rsp_entry_t e, input logic rdy, input logic clr);
        bus.in_vld      = vld;
        bus.in_sid      = e.sid;
        bus.in_rtype    = e.rtype;
        bus.in_buf_id   = e.buf_id;
        bus.in_status   = e.status;
        bus.in_err_code = e.err_code;
        bus.in_rm       = e.rm;
        bus.rsp_rdy     = rdy;
        err_clr         = clr;
    endtask

    function automatic nou_rsp_entry_t mk(input int sid, input int bid, input int rm, input int st);
        nou_rsp_entry_t e;
        e = '0;
        e.sid    = SID_W'(sid);
        e.buf_id = BUF_ID_W'(bid);
        e.rm     = RM_W'(rm);
        e.status = st[0];
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_err = 0;
        m_rel_vld = 1'b0;
        m_rel_id = '0;
        m_rel_rm = '0;
    endtask

    task automatic check_model();
        chk("occ", 32'(occ), 32'(mq.size()));
        chk("rsp_vld", 32'(bus.rsp_vld), 32'(mq.size() != 0));
        chk("retire_keep", 32'(bus.retire_keep), 32'(mq.size() == DEPTH));
        if (mq.size() != 0) begin
            chk("rsp_sid", 32'(bus.rsp_sid), 32'(mq[0].sid));
            chk("rsp_rtype", 32'(bus.rsp_rtype), 32'(mq[0].rtype));
            chk("rsp_buf_id", 32'(bus.rsp_buf_id), 32'(mq[0].buf_id));
            chk("rsp_status", 32'(bus.rsp_status), 32'(mq[0].status));
            chk("rsp_err_code", 32'(bus.rsp_err_code), 32'(mq[0].err_code));
        end
        chk("buf_rel_vld", 32'(bus.buf_rel_vld), 32'(m_rel_vld));
        chk("buf_rel_id", 32'(bus.buf_rel_id), 32'(m_rel_id));
        chk("buf_rel_rm", 32'(bus.buf_rel_rm), 32'(m_rel_rm));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    // Advance one clock: update the model from the inputs currently driven,
    // then compare after the edge.
    task automatic step();
        bit full;
        nou_rsp_entry_t h, e;
        full = (mq.size() == DEPTH);
        e = '{sid: bus.in_sid, rtype: bus.in_rtype, buf_id: bus.in_buf_id,
              status: bus.in_status, err_code: bus.in_err_code, rm: bus.in_rm};
        m_rel_vld = 1'b0;
        if (mq.size() != 0 && bus.rsp_rdy) begin
            h = mq.pop_front();
            if (h.rm != 0) begin
                m_rel_vld = 1'b1;
                m_rel_id  = h.buf_id;
                m_rel_rm  = h.rm;
            end
            if (!err_clr && h.status && m_err < ERR_MAX) m_err++;
        end
        if (err_clr) m_err = 0;
        if (bus.in_vld && !full) mq.push_back(e);
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();

        // Reset state
        #12;
        chk("rst occ", 32'(occ), 0);
        chk("rst rsp_vld", 32'(bus.rsp_vld), 0);
        chk("rst retire_keep", 32'(bus.retire_keep), 0);
        chk("rst buf_rel_vld", 32'(bus.buf_rel_vld), 0);
        chk("rst buf_rel_id", 32'(bus.buf_rel_id), 0);
        chk("rst buf_rel_rm", 32'(bus.buf_rel_rm), 0);
        chk("rst err_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table: streaming, fill-to-full with hold, full+pop, drain,
        // release pulse on rm=0011/buf_id=7 and none on rm=0.
        //            vld sid bid rm rdy  occ vld sid keep rel
        tbl[0]  = '{1, 1, 0, 0, 1,   1, 1, 1, 0, 0};
        tbl[1]  = '{1, 2, 0, 0, 1,   1, 1, 2, 0, 0};
        tbl[2]  = '{1, 3, 0, 0, 1,   1, 1, 3, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0};
        tbl[4]  = '{1, 4, 7, 3, 0,   1, 1, 4, 0, 0};
        tbl[5]  = '{1, 5, 0, 0, 0,   2, 1, 4, 0, 0};
        tbl[6]  = '{1, 6, 0, 0, 0,   3, 1, 4, 0, 0};
        tbl[7]  = '{1, 7, 0, 0, 0,   4, 1, 4, 1, 0};
        tbl[8]  = '{1, 8, 0, 0, 0,   4, 1, 4, 1, 0};
        tbl[9]  = '{1, 8, 0, 0, 1,   3, 1, 5, 0, 1};
        tbl[10] = '{1, 8, 0, 0, 0,   4, 1, 5, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 1,   3, 1, 6, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 1,   2, 1, 7, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 1,   1, 1, 8, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0};
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].vld[0], mk(tbl[i].sid, tbl[i].bid, tbl[i].rm, 0), tbl[i].rdy[0], 1'b0);
            step();
            chk($sformatf("vec%0d occ", i), 32'(occ), 32'(tbl[i].x_occ));
            chk($sformatf("vec%0d rsp_vld", i), 32'(bus.rsp_vld), 32'(tbl[i].x_vld));
            if (tbl[i].x_vld != 0)
                chk($sformatf("vec%0d rsp_sid", i), 32'(bus.rsp_sid), 32'(tbl[i].x_sid));
            chk($sformatf("vec%0d retire_keep", i), 32'(bus.retire_keep), 32'(tbl[i].x_keep));
            chk($sformatf("vec%0d buf_rel_vld", i), 32'(bus.buf_rel_vld), 32'(tbl[i].x_rel));
            if (tbl[i].x_rel != 0) begin
                chk($sformatf("vec%0d buf_rel_id", i), 32'(bus.buf_rel_id), 7);
                chk($sformatf("vec%0d buf_rel_rm", i), 32'(bus.buf_rel_rm), 3);
            end
        end

        // Error counter saturation, then clear coinciding with an error pop.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, mk(i, 0, 0, 1), 1'b1, 1'b0);
            step();
        end
        chk("err_cnt saturated", 32'(err_cnt), 32'(ERR_MAX));
        drive(1'b1, mk(9, 0, 0, 1), 1'b1, 1'b1);
        step();
        chk("err_cnt clear wins", 32'(err_cnt), 0);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk("err_cnt after clear", 32'(err_cnt), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            nou_rsp_entry_t e;
            r = $urandom;
            e = r[$bits(nou_rsp_entry_t)-1:0];
            drive(($urandom_range(0, 99) < 60), e, ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 3));
            step();
        end

        // Asynchronous reset with entries queued and a release pulse live.
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step();   // drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, mk(10 + i, 3, (i == 0) ? 1 : 0, 0), 1'b0, 1'b0);
            step();
        end
        chk("pre-rst keep", 32'(bus.retire_keep), 1);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        chk("pre-rst rel", 32'(bus.buf_rel_vld), 1);
        chk("pre-rst occ", 32'(occ), 3);
        #2;
        rstn = 1'b0;
        #1;
        chk("async rst occ", 32'(occ), 0);
        chk("async rst rsp_vld", 32'(bus.rsp_vld), 0);
        chk("async rst retire_keep", 32'(bus.retire_keep), 0);
        chk("async rst buf_rel_vld", 32'(bus.buf_rel_vld), 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
